// File: rtl/foo_sched_pkg.sv
// Shared types and constants for the foo_pipeline scheduler.
package foo_sched_pkg;

  // Fixed latency of the external foo_pipeline (input to output, in cycles).
  localparam int FOO_LAT = 2;

  // Widest requester ID carried in a tagged result; the top narrows it.
  localparam int FOO_ID_MAX_W = 8;

  typedef logic [63:0]             foo_op_t;   // {a[63:32], b[31:0]}
  typedef logic [31:0]             foo_res_t;  // a + b mod 2^32
  typedef logic [FOO_ID_MAX_W-1:0] foo_id_t;

  typedef struct packed {
    foo_res_t data;
    foo_id_t  id;
  } foo_tagged_res_t;

  // Bits needed to name one of n requesters (at least one bit).
  function automatic int foo_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/foo_sched_fifo.sv
// Synchronous result FIFO. The head is read straight from storage, so a
// pushed entry becomes visible only the cycle after the push.
module foo_sched_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 40,
  localparam int AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;

  // A pop on an empty FIFO is ignored so the count can never underflow.
  assign pop_eff = pop_i && (count_q != '0);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_eff) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers. When full with a simultaneous pop, the
  // write lands in the slot being popped, whose value was already consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/foo_pipeline_sched.sv
// Shares one non-stallable foo_pipeline among N requesters: round-robin
// arbitration, credit-based admission, ID tagging via a shadow shift
// register aligned with the pipeline, and an in-order result FIFO.
//
// Handshakes: a transfer happens in a cycle where both valid and ready are
// high at the rising clock edge (req_valid[i]/req_ready[i] per requester,
// resp_valid/resp_ready for results); ready never waits for anything but
// registered state and the current valid inputs.
module foo_pipeline_sched
  import foo_sched_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int DEPTH = 4,
  localparam int LAT   = FOO_LAT,
  localparam int IDW   = foo_id_w(N),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*64-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic [63:0]     pipe_in,
  input  logic [31:0]     pipe_out,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic [IDW-1:0]  resp_id,
  output logic            busy
);

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    grant;
  logic [IDW-1:0]  grant_idx;
  logic            issue;
  logic            can_issue;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   fifo_count;
  logic [LAT-1:0]  sh_v_q;
  logic [IDW-1:0]  sh_id_q [LAT];
  logic            tail_v;
  logic            pop;
  foo_tagged_res_t push_data;
  foo_tagged_res_t head;

  // Credit check uses registered counts only; a pop this cycle frees its
  // slot for admission starting next cycle.
  assign can_issue = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH);

  // Round-robin search from rr_ptr; one-hot grant, suppressed during reset.
  always_comb begin
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    issue     = 1'b0;
    idx       = '0;
    if (can_issue && !rst) begin
      for (int k = 0; k < N; k++) begin
        idx = IDW'((int'(rr_ptr_q) + k) % N);
        if (!issue && req_valid[idx]) begin
          issue      = 1'b1;
          grant_idx  = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign pipe_in   = issue ? req_data[grant_idx*64 +: 64] : 64'h0;

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // In-flight counter: +1 per issue, -1 when the shadow tail retires.
  always_comb begin
    case ({issue, tail_v})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Arbiter pointer, credit counter and shadow {v, id} shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      sh_v_q     <= '0;
      for (int i = 0; i < LAT; i++) sh_id_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      sh_v_q[0]  <= issue;
      sh_id_q[0] <= grant_idx;
      for (int i = 1; i < LAT; i++) begin
        sh_v_q[i]  <= sh_v_q[i-1];
        sh_id_q[i] <= sh_id_q[i-1];
      end
    end
  end

  // The shadow tail lines up with pipe_out; stale pipeline output is ignored.
  assign tail_v         = sh_v_q[LAT-1];
  assign push_data.data = pipe_out;
  assign push_data.id   = FOO_ID_MAX_W'(sh_id_q[LAT-1]);
  assign pop            = resp_valid && resp_ready;

  foo_sched_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(foo_tagged_res_t))
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tail_v),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign resp_valid = (fifo_count != '0);
  assign resp_data  = head.data;
  assign resp_id    = head.id[IDW-1:0];
  assign busy       = (inflight_q != '0) || (fifo_count != '0);

  // Credit admission must keep the FIFO from being pushed while full.
  no_overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(tail_v && (fifo_count == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_foo_pipeline_sched.sv
// Randomised and directed bench for foo_pipeline_sched with a behavioural
// foo_pipeline stand-in and a transaction-level reference model.
module tb_foo_pipeline_sched;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int QW    = 66;  // {ready_cycle[31:0], id[1:0], sum[31:0]}

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*64-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [63:0]    pipe_in;
  logic [31:0]    pipe_out;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [31:0]    resp_data;
  logic [1:0]     resp_id;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  int rv_cnt   = 0;
  int m_rr     = 0;
  int m_out    = 0;
  logic [QW-1:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  foo_pipeline_sched #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .pipe_in    (pipe_in),
    .pipe_out   (pipe_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  // Stand-in foo_pipeline: two register stages, no reset, no stall.
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    p1 <= pipe_in[63:32] + pipe_in[31:0];
    p2 <= p1;
  end
  assign pipe_out = p2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: every accepted op is owed a result LAT+1 cycles later,
  // in acceptance order; admission allowed while fewer than DEPTH ops are
  // outstanding (accepted but not yet popped before this cycle).
  always @(negedge clk) begin
    int          gi;
    logic [3:0]  eg;
    logic [31:0] s;
    logic [63:0] op;
    bit          ev;
    cyc++;
    if (rst) begin
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_resp_valid", 64'(resp_valid), 64'h0);
      check("rst_resp_data", 64'(resp_data), 64'h0);
      check("rst_resp_id", 64'(resp_id), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_pipe_in", pipe_in, 64'h0);
      exp_q.delete();
      m_rr  = 0;
      m_out = 0;
    end else begin
      gi = -1;
      eg = '0;
      if (m_out < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          if (gi < 0 && req_valid[(m_rr + k) % N]) gi = (m_rr + k) % N;
        end
      end
      op = (gi >= 0) ? req_data[gi*64 +: 64] : 64'h0;
      if (gi >= 0) eg[gi] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(eg));
      check("pipe_in", pipe_in, op);
      check("busy", 64'(busy), 64'(m_out != 0));
      ev = (exp_q.size() > 0) && (int'(exp_q[0][65:34]) <= cyc);
      check("resp_valid", 64'(resp_valid), 64'(ev));
      if (ev) begin
        check("resp_data", 64'(resp_data), 64'(exp_q[0][31:0]));
        check("resp_id", 64'(resp_id), 64'(exp_q[0][33:32]));
      end
      if (resp_valid) rv_cnt++;
      if (ev && resp_ready) begin
        void'(exp_q.pop_front());
        m_out--;
      end
      if (gi >= 0) begin
        s = op[63:32] + op[31:0];
        exp_q.push_back({32'(cyc + LAT + 1), 2'(gi), s});
        m_rr = (gi + 1) % N;
        m_out++;
        acc_cnt++;
      end
    end
  end

  // Driver: hold inputs for n cycles, optionally re-randomising the data.
  task automatic run(input logic [3:0] v, input logic rr, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      req_valid  = v;
      resp_ready = rr;
      if (rnd) begin
        for (int j = 0; j < 2 * N; j++) req_data[j*32 +: 32] = $urandom;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_data[i*64 +: 64] = {a, b};
  endtask

  initial begin
    int a0;
    int r0;
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run(4'b0000, 1'b1, 2, 1'b0);

    // Single op from requester 1: 5 + 7
    set_op(1, 32'd5, 32'd7);
    run(4'b0010, 1'b1, 1, 1'b0);
    run(4'b0000, 1'b1, 6, 1'b0);

    // Round-robin with all requesters valid and no backpressure
    run(4'b1111, 1'b1, 16, 1'b1);
    run(4'b0000, 1'b1, 6, 1'b1);

    // Backpressure: exactly DEPTH ops admitted, then drain in order
    a0 = acc_cnt;
    run(4'b1111, 1'b0, 8, 1'b1);
    check("bp_accepts", 64'(acc_cnt - a0), 64'(DEPTH));
    run(4'b1111, 1'b1, 10, 1'b1);
    run(4'b1111, 1'b0, 6, 1'b1);
    run(4'b1111, 1'b1, 3, 1'b1);
    run(4'b0000, 1'b1, 8, 1'b1);

    // 32-bit wrap
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
    set_op(2, 32'h8000_0000, 32'h8000_0000);
    run(4'b0101, 1'b1, 2, 1'b0);
    run(4'b0000, 1'b1, 6, 1'b0);

    // Reset while two ops are in flight
    run(4'b0011, 1'b1, 2, 1'b1);
    run(4'b0000, 1'b1, 1, 1'b1);
    rst = 1'b1;
    run(4'b0000, 1'b1, 1, 1'b1);
    rst = 1'b0;
    r0 = rv_cnt;
    run(4'b0000, 1'b1, 10, 1'b1);
    check("rst_no_resp", 64'(rv_cnt - r0), 64'h0);

    // Randomised traffic, mixed backpressure
    for (int i = 0; i < 400; i++) begin
      run(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1, 1'b1);
    end
    for (int i = 0; i < 200; i++) begin
      run(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1, 1'b1);
    end
    run(4'b0000, 1'b1, 12, 1'b1);
    check("final_idle_busy", 64'(busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
